// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter
// Shares one memory bus between the instruction-fetch port and the data port
// of a RISC-V core. A single request is in flight at a time. The bus command
// and the requester acks are registered. A wait counter aborts a transaction
// that the bus never acknowledges.
module riscv_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] imem_address,
    input  logic                  imem_read_req,
    output logic [DATA_WIDTH-1:0] imem_data_out,
    output logic                  imem_ack,
    input  logic [ADDR_WIDTH-1:0] dmem_address,
    input  logic [DATA_WIDTH-1:0] dmem_data_in,
    input  logic [1:0]            dmem_data_size,
    input  logic                  dmem_read_req,
    input  logic                  dmem_write_req,
    output logic [DATA_WIDTH-1:0] dmem_data_out,
    output logic                  dmem_ack,
    output logic [ADDR_WIDTH-1:0] bus_address,
    output logic [DATA_WIDTH-1:0] bus_data_out,
    output logic [1:0]            bus_data_size,
    output logic                  bus_read_req,
    output logic                  bus_write_req,
    input  logic [DATA_WIDTH-1:0] bus_data_in,
    input  logic                  bus_ack,
    output logic                  bus_error
);

    // A timeout of zero still needs a one-bit counter; it then saturates.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Count value seen in the last busy cycle allowed before the abort.
    localparam logic [CW-1:0] LAST_WAIT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CW-1:0] ONE       = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DMEM = 2'd1,
        S_IMEM = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_last_dmem;
    logic [CW-1:0]         r_count;
    logic [ADDR_WIDTH-1:0] r_bus_address;
    logic [DATA_WIDTH-1:0] r_bus_data_out;
    logic [1:0]            r_bus_data_size;
    logic                  r_bus_read_req;
    logic                  r_bus_write_req;
    logic                  r_bus_error;
    logic                  r_imem_ack;
    logic                  r_dmem_ack;
    logic [DATA_WIDTH-1:0] r_imem_data;
    logic [DATA_WIDTH-1:0] r_dmem_data;

    logic w_imem_eligible;
    logic w_dmem_eligible;
    logic w_grant_dmem;
    logic w_grant_imem;
    logic w_timeout;

    // A requester whose ack is high this cycle is still holding its old
    // request. It must not be granted a second time.
    assign w_imem_eligible = imem_read_req && !r_imem_ack;
    assign w_dmem_eligible = (dmem_read_req || dmem_write_req) && !r_dmem_ack;
    // On a tie, grant the side that was not served last.
    assign w_grant_dmem    = w_dmem_eligible && (!w_imem_eligible || !r_last_dmem);
    assign w_grant_imem    = w_imem_eligible && !w_grant_dmem;
    assign w_timeout       = (TIMEOUT_CYCLES > 0) && (r_count == LAST_WAIT);

    // Arbitration FSM: grant, hold the bus command, then complete or abort.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_last_dmem     <= 1'b0;
            r_count         <= '0;
            r_bus_address   <= '0;
            r_bus_data_out  <= '0;
            r_bus_data_size <= '0;
            r_bus_read_req  <= 1'b0;
            r_bus_write_req <= 1'b0;
            r_bus_error     <= 1'b0;
            r_imem_ack      <= 1'b0;
            r_dmem_ack      <= 1'b0;
            r_imem_data     <= '0;
            r_dmem_data     <= '0;
        end else begin
            r_imem_ack  <= 1'b0;
            r_dmem_ack  <= 1'b0;
            r_bus_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_dmem) begin
                        r_state         <= S_DMEM;
                        r_last_dmem     <= 1'b1;
                        r_count         <= '0;
                        r_bus_address   <= dmem_address;
                        r_bus_data_size <= dmem_data_size;
                        r_bus_write_req <= dmem_write_req;
                        r_bus_read_req  <= !dmem_write_req;
                        r_bus_data_out  <= dmem_write_req ? dmem_data_in : '0;
                    end else if (w_grant_imem) begin
                        r_state         <= S_IMEM;
                        r_last_dmem     <= 1'b0;
                        r_count         <= '0;
                        r_bus_address   <= imem_address;
                        r_bus_data_size <= 2'b00;
                        r_bus_write_req <= 1'b0;
                        r_bus_read_req  <= 1'b1;
                        r_bus_data_out  <= '0;
                    end
                end
                S_DMEM, S_IMEM: begin
                    if (bus_ack) begin
                        r_state         <= S_IDLE;
                        r_bus_read_req  <= 1'b0;
                        r_bus_write_req <= 1'b0;
                        if (r_state == S_IMEM) begin
                            r_imem_ack  <= 1'b1;
                            r_imem_data <= bus_data_in;
                        end else begin
                            r_dmem_ack  <= 1'b1;
                            r_dmem_data <= r_bus_write_req ? '0 : bus_data_in;
                        end
                    end else if (w_timeout) begin
                        r_state         <= S_IDLE;
                        r_bus_read_req  <= 1'b0;
                        r_bus_write_req <= 1'b0;
                        r_bus_error     <= 1'b1;
                        if (r_state == S_IMEM) begin
                            r_imem_ack  <= 1'b1;
                            r_imem_data <= '0;
                        end else begin
                            r_dmem_ack  <= 1'b1;
                            r_dmem_data <= '0;
                        end
                    end else if (r_count != '1) begin
                        r_count <= r_count + ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus_address   = r_bus_address;
    assign bus_data_out  = r_bus_data_out;
    assign bus_data_size = r_bus_data_size;
    assign bus_read_req  = r_bus_read_req;
    assign bus_write_req = r_bus_write_req;
    assign bus_error     = r_bus_error;
    assign imem_ack      = r_imem_ack;
    assign dmem_ack      = r_dmem_ack;
    assign imem_data_out = r_imem_data;
    assign dmem_data_out = r_dmem_data;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter
// Directed bench for the fetch/data bus arbiter. A bus responder acknowledges
// after a programmable number of strobe cycles. A transaction-level model
// predicts every output cycle by cycle. Literal checks pin the model itself.
module tb_riscv_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] imem_address = '0;
    logic          imem_read_req = 1'b0;
    logic [DW-1:0] imem_data_out;
    logic          imem_ack;
    logic [AW-1:0] dmem_address = '0;
    logic [DW-1:0] dmem_data_in = '0;
    logic [1:0]    dmem_data_size = 2'b00;
    logic          dmem_read_req = 1'b0;
    logic          dmem_write_req = 1'b0;
    logic [DW-1:0] dmem_data_out;
    logic          dmem_ack;
    logic [AW-1:0] bus_address;
    logic [DW-1:0] bus_data_out;
    logic [1:0]    bus_data_size;
    logic          bus_read_req;
    logic          bus_write_req;
    logic [DW-1:0] bus_data_in;
    logic          bus_ack;
    logic          bus_error;

    int vectors = 0;
    int miscompares = 0;

    riscv_mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_address(imem_address), .imem_read_req(imem_read_req),
        .imem_data_out(imem_data_out), .imem_ack(imem_ack),
        .dmem_address(dmem_address), .dmem_data_in(dmem_data_in),
        .dmem_data_size(dmem_data_size), .dmem_read_req(dmem_read_req),
        .dmem_write_req(dmem_write_req), .dmem_data_out(dmem_data_out),
        .dmem_ack(dmem_ack), .bus_address(bus_address), .bus_data_out(bus_data_out),
        .bus_data_size(bus_data_size), .bus_read_req(bus_read_req),
        .bus_write_req(bus_write_req), .bus_data_in(bus_data_in),
        .bus_ack(bus_ack), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    // Hard stop in case a wait ever runs away.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    // Bus responder. It raises bus_ack in the ackAt-th consecutive strobe
    // cycle (0 = never). It returns either fixed data or data derived from the
    // address.
    int            ackAt = 1;
    int            strobeCycles = 0;
    logic          forceAck = 1'b0;
    logic          useFixed = 1'b0;
    logic [DW-1:0] fixedData = '0;

    initial begin
        bus_ack = 1'b0;
        bus_data_in = '0;
        forever begin
            @(posedge clk);
            #2;
            if (bus_read_req || bus_write_req) strobeCycles++;
            else strobeCycles = 0;
            bus_ack = forceAck || (ackAt != 0 && strobeCycles == ackAt);
            bus_data_in = useFixed ? fixedData : (bus_address ^ 32'h5A5A_0000);
        end
    end

    // Transaction-level reference: who owns the bus, what was captured at
    // grant, how long it has waited, and what pulses come next.
    int            mOwner = 0;
    bit            mLastData = 1'b0;
    int            mWaited = 0;
    logic [AW-1:0] mAddr = '0;
    logic [DW-1:0] mWdata = '0;
    logic [1:0]    mSize = '0;
    bit            mWrite = 1'b0;
    logic          eIAck = 1'b0, eDAck = 1'b0, eErr = 1'b0;
    logic [DW-1:0] eIData = '0, eDData = '0;
    bit            wantI, wantD;
    logic          eRd, eWr;

    assign eRd = (mOwner != 0) && !mWrite;
    assign eWr = (mOwner != 0) && mWrite;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mOwner = 0; mLastData = 1'b0; mWaited = 0; mWrite = 1'b0;
            eIAck = 1'b0; eDAck = 1'b0; eErr = 1'b0; eIData = '0; eDData = '0;
        end else begin
            wantI = imem_read_req && !eIAck;
            wantD = (dmem_read_req || dmem_write_req) && !eDAck;
            eIAck = 1'b0; eDAck = 1'b0; eErr = 1'b0;
            if (mOwner == 0) begin
                if (wantD && (!wantI || !mLastData)) begin
                    mOwner = 2; mLastData = 1'b1; mWaited = 0;
                    mAddr = dmem_address; mWrite = dmem_write_req;
                    mWdata = dmem_data_in; mSize = dmem_data_size;
                end else if (wantI) begin
                    mOwner = 1; mLastData = 1'b0; mWaited = 0;
                    mAddr = imem_address; mWrite = 1'b0; mWdata = '0; mSize = 2'b00;
                end
            end else if (bus_ack) begin
                if (mOwner == 1) begin eIAck = 1'b1; eIData = bus_data_in; end
                else begin eDAck = 1'b1; eDData = mWrite ? '0 : bus_data_in; end
                mOwner = 0; mWrite = 1'b0;
            end else begin
                mWaited++;
                if (TMO > 0 && mWaited >= TMO) begin
                    if (mOwner == 1) begin eIAck = 1'b1; eIData = '0; end
                    else begin eDAck = 1'b1; eDData = '0; end
                    eErr = 1'b1; mOwner = 0; mWrite = 1'b0;
                end
            end
        end
    end

    // Compare every output against the reference, midway through each cycle.
    always @(negedge clk) begin
        checkOutput("bus_read_req", 32'(bus_read_req), 32'(eRd));
        checkOutput("bus_write_req", 32'(bus_write_req), 32'(eWr));
        checkOutput("imem_ack", 32'(imem_ack), 32'(eIAck));
        checkOutput("dmem_ack", 32'(dmem_ack), 32'(eDAck));
        checkOutput("bus_error", 32'(bus_error), 32'(eErr));
        checkOutput("single_ack", 32'(imem_ack && dmem_ack), 32'd0);
        if (eRd || eWr) begin
            checkOutput("bus_address", bus_address, mAddr);
            checkOutput("bus_data_size", 32'(bus_data_size), 32'(mSize));
        end
        if (eWr || mOwner == 1) checkOutput("bus_data_out", bus_data_out, mWdata);
        if (eIAck) checkOutput("imem_data_out", imem_data_out, eIData);
        if (eDAck) checkOutput("dmem_data_out", dmem_data_out, eDData);
        if (!reset_n) begin
            checkOutput("reset_bus_address", bus_address, 32'd0);
            checkOutput("reset_imem_data", imem_data_out, 32'd0);
            checkOutput("reset_dmem_data", dmem_data_out, 32'd0);
        end
    end

    // One cycle. A requester drops its request in the cycle after its ack.
    bit lastI, lastD;
    task automatic step();
        @(negedge clk);
        lastI = imem_ack;
        lastD = dmem_ack;
        @(posedge clk);
        #1;
        if (lastI) imem_read_req = 1'b0;
        if (lastD) begin dmem_read_req = 1'b0; dmem_write_req = 1'b0; end
    endtask

    task automatic waitDone(input int limit);
        int n = 0;
        while ((imem_read_req || dmem_read_req || dmem_write_req) && n < limit) begin
            step();
            n++;
        end
        vectors++;
        if (imem_read_req || dmem_read_req || dmem_write_req) begin
            miscompares++;
            $display("[TB] FAIL wait_done: requests still pending after %0d cycles, required none", limit);
            imem_read_req = 1'b0; dmem_read_req = 1'b0; dmem_write_req = 1'b0;
        end
        step();
    endtask

    // kind: 0 fetch, 1 load, 2 store, 3 fetch+load together
    task automatic applyStimulus(input int kind, input logic [31:0] base);
        if (kind == 0 || kind == 3) begin imem_address = base; imem_read_req = 1'b1; end
        if (kind == 1 || kind == 3) begin dmem_address = base + 32'h1000; dmem_read_req = 1'b1; end
        if (kind == 2) begin
            dmem_address = base + 32'h2000; dmem_data_in = ~base;
            dmem_data_size = 2'b10; dmem_write_req = 1'b1;
        end
    endtask

    int kinds[6]  = '{3, 2, 0, 1, 3, 2};
    int delays[6] = '{2, 3, 1, 4, 1, 7};

    initial begin
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        checkOutput("reset_read_req", 32'(bus_read_req), 32'd0);
        checkOutput("reset_imem_ack", 32'(imem_ack), 32'd0);
        #1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single fetch, acked in the first strobe cycle.
        useFixed = 1'b1; fixedData = 32'hDEADBEEF; ackAt = 1;
        imem_address = 32'h100; imem_read_req = 1'b1;
        #3; checkOutput("fetch_c0_strobe", 32'(bus_read_req), 32'd0);
        step(); #3;
        checkOutput("fetch_c1_strobe", 32'(bus_read_req), 32'd1);
        checkOutput("fetch_c1_addr", bus_address, 32'h100);
        step(); #3;
        checkOutput("fetch_c2_ack", 32'(imem_ack), 32'd1);
        checkOutput("fetch_c2_data", imem_data_out, 32'hDEADBEEF);
        checkOutput("fetch_c2_strobe", 32'(bus_read_req), 32'd0);
        step(); #3;
        checkOutput("fetch_c3_no_regrant", 32'(bus_read_req), 32'd0);
        checkOutput("fetch_c3_ack", 32'(imem_ack), 32'd0);
        useFixed = 1'b0;
        step();

        // Tie after reset: data first, fetch right after the data ack.
        imem_address = 32'h40; imem_read_req = 1'b1;
        dmem_address = 32'h3000; dmem_read_req = 1'b1;
        step(); #3;
        checkOutput("tie1_dmem_addr", bus_address, 32'h3000);
        step(); #3;
        checkOutput("tie1_dmem_ack", 32'(dmem_ack), 32'd1);
        checkOutput("tie1_dmem_data", dmem_data_out, 32'h5A5A3000);
        step(); #3;
        checkOutput("tie1_imem_addr", bus_address, 32'h40);
        checkOutput("tie1_imem_strobe", 32'(bus_read_req), 32'd1);
        step(); #3;
        checkOutput("tie1_imem_data", imem_data_out, 32'h5A5A0040);
        waitDone(20);

        // Fetch was last: next tie goes to data.
        applyStimulus(3, 32'h44);
        step(); #3;
        checkOutput("tie2_dmem_first", bus_address, 32'h1044);
        waitDone(20);
        // Data was last: next tie goes to fetch.
        applyStimulus(1, 32'h48);
        waitDone(20);
        applyStimulus(3, 32'h4C);
        step(); #3;
        checkOutput("tie3_imem_first", bus_address, 32'h4C);
        waitDone(20);

        // Store with read also raised, bus ack delayed; inputs change after grant.
        ackAt = 6;
        dmem_address = 32'h2000; dmem_data_in = 32'h12345678; dmem_data_size = 2'b01;
        dmem_write_req = 1'b1; dmem_read_req = 1'b1;
        step();
        dmem_address = 32'hFFFF0000; dmem_data_in = '0; dmem_data_size = 2'b11;
        for (int i = 0; i < 5; i++) begin
            #3;
            checkOutput("store_write_strobe", 32'(bus_write_req), 32'd1);
            checkOutput("store_read_strobe", 32'(bus_read_req), 32'd0);
            checkOutput("store_addr", bus_address, 32'h2000);
            checkOutput("store_data", bus_data_out, 32'h12345678);
            checkOutput("store_size", 32'(bus_data_size), 32'd1);
            step();
        end
        step(); #3;
        checkOutput("store_ack", 32'(dmem_ack), 32'd1);
        checkOutput("store_ack_data", dmem_data_out, 32'd0);
        waitDone(20);
        dmem_data_size = 2'b00;

        // Load to leave nonzero read data, then a load that times out.
        ackAt = 1; applyStimulus(1, 32'h600); waitDone(20);
        ackAt = 0;
        dmem_address = 32'h500; dmem_read_req = 1'b1;
        step();
        for (int i = 0; i < TMO; i++) begin
            #3;
            checkOutput("timeout_strobe", 32'(bus_read_req), 32'd1);
            checkOutput("timeout_no_err", 32'(bus_error), 32'd0);
            step();
        end
        #3;
        checkOutput("timeout_error", 32'(bus_error), 32'd1);
        checkOutput("timeout_ack", 32'(dmem_ack), 32'd1);
        checkOutput("timeout_data", dmem_data_out, 32'd0);
        checkOutput("timeout_strobe_drop", 32'(bus_read_req), 32'd0);
        step(); #3;
        checkOutput("timeout_err_pulse", 32'(bus_error), 32'd0);
        ackAt = 2;
        imem_address = 32'h80; imem_read_req = 1'b1;
        step(); #3;
        checkOutput("after_timeout_grant", bus_address, 32'h80);
        waitDone(20);

        // Ack arrives in the last allowed cycle: completion wins over timeout.
        ackAt = TMO;
        dmem_address = 32'h700; dmem_read_req = 1'b1;
        repeat (TMO + 1) step();
        #3;
        checkOutput("edge_ack", 32'(dmem_ack), 32'd1);
        checkOutput("edge_no_error", 32'(bus_error), 32'd0);
        checkOutput("edge_data", dmem_data_out, 32'h5A5A1700 ^ 32'h00001000);
        waitDone(20);

        // Stray bus ack while idle.
        forceAck = 1'b1;
        step();
        forceAck = 1'b0;
        #3;
        checkOutput("stray_imem_ack", 32'(imem_ack), 32'd0);
        checkOutput("stray_dmem_ack", 32'(dmem_ack), 32'd0);
        step();

        // Reset during a data wait aborts silently.
        ackAt = 0;
        dmem_address = 32'h900; dmem_data_in = 32'hCAFE; dmem_write_req = 1'b1;
        step(); step(); step();
        #2;
        checkOutput("pre_reset_strobe", 32'(bus_write_req), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_write", 32'(bus_write_req), 32'd0);
        checkOutput("async_reset_read", 32'(bus_read_req), 32'd0);
        dmem_write_req = 1'b0;
        step(); step();
        reset_n = 1'b1;
        ackAt = 1;
        dmem_address = 32'h904; dmem_write_req = 1'b1;
        step(); #3;
        checkOutput("reissue_strobe", 32'(bus_write_req), 32'd1);
        checkOutput("reissue_addr", bus_address, 32'h904);
        waitDone(20);

        // Mixed back-to-back traffic with varied bus latencies.
        for (int k = 0; k < 6; k++) begin
            ackAt = delays[k];
            applyStimulus(kinds[k], 32'h400 + 32'(k * 16));
            waitDone(40);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
